// File: rtl/note2dds_pkg.sv
// Shared constants, tuning table and FSM states for note2dds_mch.
// Top-octave increments assume a 50 MHz sample clock and 32-bit phase.
package note2dds_pkg;

  localparam int CLK_HZ  = 50_000_000;
  localparam int OCT_TOP = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV,
    S_INTERP,
    S_SHIFT,
    S_WRITE
  } state_e;

  // round(f * 2^32 / CLK_HZ) for MIDI notes 120..131
  function automatic logic [31:0] base_inc(
    input logic [3:0] idx
  );
    logic [31:0] v;
    v = 32'd0;
    case (idx)
      4'd0:    v = 32'd719151;
      4'd1:    v = 32'd761914;
      4'd2:    v = 32'd807220;
      4'd3:    v = 32'd855219;
      4'd4:    v = 32'd906073;
      4'd5:    v = 32'd959951;
      4'd6:    v = 32'd1017033;
      4'd7:    v = 32'd1077509;
      4'd8:    v = 32'd1141581;
      4'd9:    v = 32'd1209463;
      4'd10:   v = 32'd1281381;
      4'd11:   v = 32'd1357576;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/note2dds_acc.sv
// One voice channel: increment register plus phase accumulator.
// Clear has priority over the sample tick.
module note2dds_acc #(
  parameter int ACC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [ACC_W-1:0] inc_i,
  input  logic             clr_i,
  input  logic             tick_i,
  output logic [ACC_W-1:0] phase_o
);

  logic [ACC_W-1:0] inc_q;
  logic [ACC_W-1:0] phase_q;
  logic [ACC_W-1:0] phase_d;

  // tick uses the increment held before a same-cycle write
  always_comb begin
    phase_d = phase_q;
    if (clr_i)
      phase_d = '0;
    else if (tick_i)
      phase_d = phase_q + inc_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inc_q   <= '0;
      phase_q <= '0;
    end else begin
      if (wr_i)
        inc_q <= inc_i;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/note2dds_mch.sv
// Multichannel MIDI note + bend to DDS increment converter.
// NOTE2DDS_PHASE_RESET_EN: note-on write also clears that channel's phase.
module note2dds_mch
  import note2dds_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int ACC_W  = 32,
  parameter int BEND_W = 8,
  parameter int CHW    = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 REQ,
  output logic                 READY,
  input  logic [CHW-1:0]       CH,
  input  logic [7:0]           NOTE,
  input  logic [BEND_W-1:0]    BEND,
  input  logic                 OFF,
  output logic                 DONE,
  output logic [ACC_W-1:0]     ADDER,
  input  logic                 TICK,
  output logic [NCH*ACC_W-1:0] PHASE
);

  localparam int FW = ACC_W + BEND_W;

  state_e            state_q;
  logic [6:0]        rem_q;
  logic [3:0]        oct_q;
  logic [CHW-1:0]    ch_q;
  logic [BEND_W-1:0] bend_q;
  logic [FW-1:0]     full_q;
  logic [ACC_W-1:0]  adder_q;
  logic              ready_q;
  logic              done_q;
`ifdef NOTE2DDS_PHASE_RESET_EN
  logic              off_q;
`endif

  logic [6:0]       note_c;
  logic             top_c;
  logic [FW-1:0]    lo_c;
  logic [FW-1:0]    hi_c;
  logic [FW-1:0]    prod_c;
  logic [FW-1:0]    full_c;
  logic [3:0]       sh_c;
  logic [ACC_W-1:0] res_c;

  assign note_c = NOTE[7] ? 7'd127 : NOTE[6:0];
  assign top_c  = (rem_q == 7'd11);
  assign lo_c   = FW'(base_inc(rem_q[3:0]));

  // semitone above B wraps to the next octave's C
  assign hi_c   = top_c ? (FW'(base_inc(4'd0)) << 1)
                        : FW'(base_inc(rem_q[3:0] + 4'd1));
  assign prod_c = (hi_c - lo_c) * FW'(bend_q);
  assign full_c = lo_c + (prod_c >> BEND_W);
  assign sh_c   = 4'(OCT_TOP) - oct_q;
  assign res_c  = ACC_W'(full_q >> sh_c);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      oct_q   <= '0;
      ch_q    <= '0;
      bend_q  <= '0;
      full_q  <= '0;
      adder_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef NOTE2DDS_PHASE_RESET_EN
      off_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (REQ) begin
            ch_q    <= CH;
            bend_q  <= BEND;
            ready_q <= 1'b0;
`ifdef NOTE2DDS_PHASE_RESET_EN
            off_q   <= OFF;
`endif
            if (OFF) begin
              adder_q <= '0;
              done_q  <= 1'b1;
              state_q <= S_WRITE;
            end else begin
              rem_q   <= note_c;
              oct_q   <= 4'd0;
              state_q <= S_DIV;
            end
          end
        end
        S_DIV: begin
          if (rem_q >= 7'd12) begin
            rem_q <= rem_q - 7'd12;
            oct_q <= oct_q + 4'd1;
          end else begin
            state_q <= S_INTERP;
          end
        end
        S_INTERP: begin
          full_q  <= full_c;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          adder_q <= res_c;
          done_q  <= 1'b1;
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign READY = ready_q;
  assign DONE  = done_q;
  assign ADDER = adder_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic wr;
    logic clr;
    assign wr = (state_q == S_WRITE) && (ch_q == CHW'(k));
`ifdef NOTE2DDS_PHASE_RESET_EN
    assign clr = wr && !off_q;
`else
    assign clr = 1'b0;
`endif
    note2dds_acc #(
      .ACC_W (ACC_W)
    ) u_acc (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .wr_i    (wr),
      .inc_i   (adder_q),
      .clr_i   (clr),
      .tick_i  (TICK),
      .phase_o (PHASE[k*ACC_W +: ACC_W])
    );
  end

endmodule

// File: tb/tb_note2dds_mch.sv
// Directed bench for note2dds_mch (3 channels, so CH=3 is out of range).
// Expected increments are hand-derived from the top-octave table.
module tb_note2dds_mch;

  localparam int NCH = 3;
  localparam int AW  = 32;

  logic          CLK   = 1'b0;
  logic          RST_N = 1'b0;
  logic          REQ   = 1'b0;
  logic          TICK  = 1'b0;
  logic          OFF   = 1'b0;
  logic [1:0]    CH    = '0;
  logic [7:0]    NOTE  = '0;
  logic [7:0]    BEND  = '0;
  logic          READY;
  logic          DONE;
  logic [AW-1:0] ADDER;
  logic [NCH*AW-1:0] PHASE;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_ph  [NCH];
  logic [31:0] exp_inc [NCH];

  int          lat;
  logic [31:0] add;
  int          rdy_bad;
  logic        rdy_after;
  logic        done_after;
  logic [31:0] ph;

  always #5 CLK = ~CLK;

  note2dds_mch #(
    .NCH    (NCH),
    .ACC_W  (AW),
    .BEND_W (8),
    .CHW    (2)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .READY (READY),
    .CH    (CH),
    .NOTE  (NOTE),
    .BEND  (BEND),
    .OFF   (OFF),
    .DONE  (DONE),
    .ADDER (ADDER),
    .TICK  (TICK),
    .PHASE (PHASE)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_tick();
    for (int k = 0; k < NCH; k++)
      exp_ph[k] = exp_ph[k] + exp_inc[k];
  endtask

  task automatic model_clear();
    for (int k = 0; k < NCH; k++) begin
      exp_ph[k]  = '0;
      exp_inc[k] = '0;
    end
  endtask

  task automatic model_on(input int ch, input logic [31:0] inc);
    exp_inc[ch] = inc;
`ifdef NOTE2DDS_PHASE_RESET_EN
    exp_ph[ch] = '0;
`endif
  endtask

  task automatic do_ticks(input int n);
    TICK = 1'b1;
    repeat (n) begin
      step();
      model_tick();
    end
    TICK = 1'b0;
  endtask

  task automatic run_conv(
    input  logic [1:0]  ch,
    input  logic [7:0]  note,
    input  logic [7:0]  bend,
    input  logic        off,
    input  logic        tick_done,
    input  logic        hold,
    output int          lat_o,
    output logic [31:0] add_o,
    output int          rdy_bad_o,
    output logic        rdy_after_o,
    output logic        done_after_o
  );
    CH   = ch;
    NOTE = note;
    BEND = bend;
    OFF  = off;
    REQ  = 1'b1;
    step();
    if (hold) begin
      NOTE = 8'd30;
      BEND = 8'd7;
      OFF  = 1'b0;
    end else begin
      REQ = 1'b0;
    end
    lat_o     = 0;
    rdy_bad_o = 0;
    for (int n = 1; n <= 40; n++) begin
      if (READY !== 1'b0) rdy_bad_o++;
      if (DONE === 1'b1) begin
        lat_o = n;
        break;
      end
      step();
    end
    add_o = ADDER;
    REQ   = 1'b0;
    if (tick_done) TICK = 1'b1;
    step();
    if (tick_done) begin
      model_tick();
      TICK = 1'b0;
    end
    rdy_after_o  = READY;
    done_after_o = DONE;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if (READY !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b want 1", READY);
    end
    checks++;
    if (DONE !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got %b want 0", DONE);
    end
    checks++;
    if (ADDER !== 32'd0) begin
      errors++;
      $display("FAIL rst_adder got %0d want 0", ADDER);
    end
    checks++;
    if (PHASE !== '0) begin
      errors++;
      $display("FAIL rst_phase got %h want 0", PHASE);
    end
    step();
    RST_N = 1'b1;
    model_clear();
    step();
  endtask

  task automatic test_note69();
    run_conv(2'd0, 8'd69, 8'd0, 1'b0, 1'b0, 1'b0,
             lat, add, rdy_bad, rdy_after, done_after);
    model_on(0, 32'd37795);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL n69_lat got %0d want 9", lat);
    end
    checks++;
    if (add !== 32'd37795) begin
      errors++;
      $display("FAIL n69_adder got %0d want 37795", add);
    end
    checks++;
    if (rdy_bad !== 0) begin
      errors++;
      $display("FAIL n69_busy got %0d want 0", rdy_bad);
    end
    checks++;
    if (rdy_after !== 1'b1 || done_after !== 1'b0) begin
      errors++;
      $display("FAIL n69_after got %b%b want 10",
               rdy_after, done_after);
    end
    do_ticks(3);
    ph = PHASE[0 +: 32];
    checks++;
    if (ph !== 32'd113385) begin
      errors++;
      $display("FAIL n69_phase got %0d want 113385", ph);
    end
  endtask

  task automatic test_range();
    logic [7:0]  notes [3];
    logic [31:0] adds  [3];
    int          lats  [3];
    notes = '{8'd127, 8'd0, 8'd168};
    adds  = '{32'd1077509, 32'd702, 32'd1077509};
    lats  = '{14, 4, 14};
    for (int i = 0; i < 3; i++) begin
      run_conv(2'd3, notes[i], 8'd0, 1'b0, 1'b0, 1'b0,
               lat, add, rdy_bad, rdy_after, done_after);
      checks++;
      if (lat !== lats[i]) begin
        errors++;
        $display("FAIL range_lat note %0d got %0d want %0d",
                 notes[i], lat, lats[i]);
      end
      checks++;
      if (add !== adds[i]) begin
        errors++;
        $display("FAIL range_adder note %0d got %0d want %0d",
                 notes[i], add, adds[i]);
      end
    end
    do_ticks(1);
    for (int k = 0; k < NCH; k++) begin
      ph = PHASE[k*AW +: AW];
      checks++;
      if (ph !== exp_ph[k]) begin
        errors++;
        $display("FAIL range_phase%0d got %0d want %0d",
                 k, ph, exp_ph[k]);
      end
    end
  endtask

  task automatic test_bend_busy();
    int extra;
    run_conv(2'd1, 8'd69, 8'd128, 1'b0, 1'b0, 1'b1,
             lat, add, rdy_bad, rdy_after, done_after);
    model_on(1, 32'd38919);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL bend_lat got %0d want 9", lat);
    end
    checks++;
    if (add !== 32'd38919) begin
      errors++;
      $display("FAIL bend_adder got %0d want 38919", add);
    end
    checks++;
    if (rdy_bad !== 0) begin
      errors++;
      $display("FAIL bend_busy got %0d want 0", rdy_bad);
    end
    extra = 0;
    repeat (6) begin
      if (DONE !== 1'b0) extra++;
      step();
    end
    checks++;
    if (extra !== 0 || ADDER !== 32'd38919) begin
      errors++;
      $display("FAIL bend_noqueue got %0d/%0d want 0/38919",
               extra, ADDER);
    end
  endtask

  task automatic test_off();
    run_conv(2'd2, 8'd60, 8'd0, 1'b0, 1'b0, 1'b0,
             lat, add, rdy_bad, rdy_after, done_after);
    model_on(2, 32'd22473);
    checks++;
    if (add !== 32'd22473) begin
      errors++;
      $display("FAIL n60_adder got %0d want 22473", add);
    end
    do_ticks(2);
    run_conv(2'd2, 8'd60, 8'd0, 1'b1, 1'b1, 1'b0,
             lat, add, rdy_bad, rdy_after, done_after);
    exp_inc[2] = '0;
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL off_lat got %0d want 1", lat);
    end
    checks++;
    if (add !== 32'd0) begin
      errors++;
      $display("FAIL off_adder got %0d want 0", add);
    end
    do_ticks(2);
    ph = PHASE[2*AW +: AW];
    checks++;
    if (ph !== 32'd67419) begin
      errors++;
      $display("FAIL off_phase got %0d want 67419", ph);
    end
    for (int k = 0; k < 2; k++) begin
      ph = PHASE[k*AW +: AW];
      checks++;
      if (ph !== exp_ph[k]) begin
        errors++;
        $display("FAIL off_phase%0d got %0d want %0d",
                 k, ph, exp_ph[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    CH   = 2'd0;
    NOTE = 8'd127;
    BEND = 8'd0;
    OFF  = 1'b0;
    REQ  = 1'b1;
    step();
    REQ = 1'b0;
    repeat (4) step();
    #2;
    RST_N = 1'b0;
    #1;
    model_clear();
    checks++;
    if (READY !== 1'b1 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_ctl got %b%b want 10", READY, DONE);
    end
    checks++;
    if (PHASE !== '0 || ADDER !== 32'd0) begin
      errors++;
      $display("FAIL mid_rst_data got %h/%0d want 0/0",
               PHASE, ADDER);
    end
    step();
    RST_N = 1'b1;
    dn = 0;
    repeat (20) begin
      step();
      if (DONE !== 1'b0) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL mid_rst_nodone got %0d want 0", dn);
    end
    run_conv(2'd0, 8'd69, 8'd0, 1'b0, 1'b0, 1'b0,
             lat, add, rdy_bad, rdy_after, done_after);
    model_on(0, 32'd37795);
    checks++;
    if (lat !== 9 || add !== 32'd37795) begin
      errors++;
      $display("FAIL mid_rst_redo got %0d/%0d want 9/37795",
               lat, add);
    end
    do_ticks(1);
    ph = PHASE[0 +: 32];
    checks++;
    if (ph !== 32'd37795) begin
      errors++;
      $display("FAIL mid_rst_phase got %0d want 37795", ph);
    end
  endtask

  task automatic test_phase_reset();
    logic [31:0] want;
    run_conv(2'd1, 8'd69, 8'd0, 1'b0, 1'b0, 1'b0,
             lat, add, rdy_bad, rdy_after, done_after);
    model_on(1, 32'd37795);
    do_ticks(5);
    ph = PHASE[AW +: AW];
    checks++;
    if (ph !== 32'd188975) begin
      errors++;
      $display("FAIL pr_before got %0d want 188975", ph);
    end
    run_conv(2'd1, 8'd81, 8'd0, 1'b0, 1'b0, 1'b0,
             lat, add, rdy_bad, rdy_after, done_after);
    model_on(1, 32'd75591);
    checks++;
    if (lat !== 10 || add !== 32'd75591) begin
      errors++;
      $display("FAIL pr_n81 got %0d/%0d want 10/75591", lat, add);
    end
`ifdef NOTE2DDS_PHASE_RESET_EN
    want = 32'd0;
`else
    want = 32'd188975;
`endif
    ph = PHASE[AW +: AW];
    checks++;
    if (ph !== want) begin
      errors++;
      $display("FAIL pr_after got %0d want %0d", ph, want);
    end
    do_ticks(2);
    for (int k = 0; k < NCH; k++) begin
      ph = PHASE[k*AW +: AW];
      checks++;
      if (ph !== exp_ph[k]) begin
        errors++;
        $display("FAIL pr_phase%0d got %0d want %0d",
                 k, ph, exp_ph[k]);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_note69();
    test_range();
    test_bend_busy();
    test_off();
    test_reset_mid();
    test_phase_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
